// File: rtl/acadia_sync_filter.sv
// acadia_sync_filter
// Multi-channel conditioner for asynchronous level inputs. Each channel
// passes through a SYNC_STAGES-deep flop synchronizer and then a debounce
// filter that only lets data_out follow after FILTER_CYCLES consecutive
// cycles of disagreement. The same edge that changes data_out also
// produces a one-cycle rise or fall pulse.
module acadia_sync_filter #(
  parameter int               WIDTH         = 4,
  parameter int               SYNC_STAGES   = 2,
  parameter int               FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  input  logic             hold,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  // Counter wide enough for 0..FILTER_CYCLES-1, never narrower than 1 bit.
  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  // Out-of-range parameters stop elaboration instead of building a
  // synchronizer with too little metastability protection.
  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
      $error("acadia_sync_filter: SYNC_STAGES must be in 2..4");
    end
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter_cycles
      $error("acadia_sync_filter: FILTER_CYCLES must be in 1..255");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("acadia_sync_filter: WIDTH must be in 1..32");
    end
  endgenerate

  // Synchronizer chain: sync_reg[0] samples the pads, the last stage is
  // the first value considered safe to use in this clock domain.
  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;

  // Per-channel filter state and its next-state values.
  logic [CNT_W-1:0] cnt_reg  [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_reg;
  logic [WIDTH-1:0] fall_next;
  logic [WIDTH-1:0] differs;
  logic [WIDTH-1:0] done;

  // Shift the synchronizer every cycle; hold deliberately does not stop it
  // so the chain always reflects the current pad level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_reg[k] <= RESET_VAL;
      end
    end else begin
      sync_reg[0] <= async_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_reg[k] <= sync_reg[k-1];
      end
    end
  end

  assign sync_s = sync_reg[SYNC_STAGES-1];

  // Per-channel debounce decision. A channel only changes once it has
  // disagreed with data_out for FILTER_CYCLES evaluations in a row; any
  // agreement in between (a short glitch) clears the count.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      assign differs[gi]   = sync_s[gi] ^ data_reg[gi];
      assign done[gi]      = differs[gi] && (cnt_reg[gi] == CNT_MAX);
      assign cnt_next[gi]  = (!differs[gi] || done[gi]) ? '0
                                                        : cnt_reg[gi] + CNT_W'(1);
      assign data_next[gi] = done[gi] ? sync_s[gi] : data_reg[gi];
      assign rise_next[gi] = done[gi] &  sync_s[gi];
      assign fall_next[gi] = done[gi] & ~sync_s[gi];
    end
  endgenerate

  // Filter state update. While hold is high the levels and counts freeze,
  // but pulses are still cleared so no event is ever stretched by hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < WIDTH; c++) begin
        cnt_reg[c] <= '0;
      end
      data_reg <= RESET_VAL;
      rise_reg <= '0;
      fall_reg <= '0;
    end else if (hold) begin
      rise_reg <= '0;
      fall_reg <= '0;
    end else begin
      for (int c = 0; c < WIDTH; c++) begin
        cnt_reg[c] <= cnt_next[c];
      end
      data_reg <= data_next;
      rise_reg <= rise_next;
      fall_reg <= fall_next;
    end
  end

  assign data_out   = data_reg;
  assign rise       = rise_reg;
  assign fall       = fall_reg;
  assign any_change = |(rise_reg | fall_reg);

endmodule
